// File: rtl/gcd_operand_loader.sv
// AXI4 write-burst master: turns a (base address, beat count) command plus a
// word stream into one INCR burst, then reports BRESP on a one-cycle status pulse.
module gcd_operand_loader #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 64,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                  CLK,
    input  logic                  RESET,

    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [ADDR_W-1:0]     CMD_ADDR,
    input  logic [7:0]            CMD_LEN,

    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_W-1:0]     IN_DATA,

    output logic [3:0]            M_AXI_AWID,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWLOCK,
    output logic [3:0]            M_AXI_AWCACHE,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,

    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,

    input  logic [3:0]            M_AXI_BID,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,

    output logic                  STS_VALID,
    output logic [1:0]            STS_RESP,
    output logic                  BUSY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SIZE   = $clog2(STRB_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_len;
    logic [7:0]          r_beat;
    logic                r_awvalid;
    logic                r_bready;
    logic                r_sts_valid;
    logic [1:0]          r_sts_resp;

    logic [15:0]         w_bytes;
    logic [15:0]         w_end;
    logic                w_misalign;
    logic                w_cross;
    logic                w_reject;
    logic                w_in_data;
    logic                w_w_hs;
    logic                w_last;
    logic                w_unused;

    // Burst end offset within its 4KB page; ending exactly on the boundary is legal.
    assign w_bytes    = ({8'd0, CMD_LEN} + 16'd1) << SIZE;
    assign w_end      = {4'd0, CMD_ADDR[11:0]} + w_bytes;
    assign w_misalign = |CMD_ADDR[SIZE-1:0];
    assign w_cross    = w_end > 16'd4096;
    assign w_reject   = w_misalign | w_cross;

    assign w_in_data  = (r_state == S_DATA) && !RESET;
    assign w_last     = (r_beat == r_len);
    assign w_w_hs     = IN_VALID && M_AXI_WREADY;
    assign w_unused   = ^M_AXI_BID;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_awvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_sts_valid <= 1'b0;
            r_sts_resp  <= 2'b00;
        end else begin
            r_sts_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        r_addr <= CMD_ADDR;
                        r_len  <= CMD_LEN;
                        if (w_reject) begin
                            r_sts_valid <= 1'b1;
                            r_sts_resp  <= 2'b10;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_state   <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    // Count stops at LEN so a 256-beat burst never wraps before WLAST.
                    if (w_w_hs) begin
                        if (w_last) begin
                            r_bready <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_sts_valid <= 1'b1;
                        r_sts_resp  <= M_AXI_BRESP;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CMD_READY     = (r_state == S_IDLE) && !RESET;
    assign BUSY          = (r_state != S_IDLE) && !RESET;
    assign STS_VALID     = r_sts_valid && !RESET;
    assign STS_RESP      = RESET ? 2'b00 : r_sts_resp;

    assign M_AXI_AWID    = AXI_ID;
    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWLEN   = r_len;
    assign M_AXI_AWSIZE  = 3'(SIZE);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'd0;
    assign M_AXI_AWPROT  = 3'd0;
    assign M_AXI_AWVALID = r_awvalid && !RESET;

    // Zero-latency pass-through: the stream source sees WREADY directly.
    assign M_AXI_WDATA   = IN_DATA;
    assign M_AXI_WSTRB   = {STRB_W{1'b1}};
    assign M_AXI_WVALID  = w_in_data && IN_VALID;
    assign M_AXI_WLAST   = w_in_data && w_last;
    assign IN_READY      = w_in_data && M_AXI_WREADY;

    assign M_AXI_BREADY  = r_bready && !RESET;

endmodule

// File: tb/tb_gcd_operand_loader.sv
// Directed + randomized bench for gcd_operand_loader with a behavioural AXI slave
// monitor and a reference model of the accept/reject and burst rules.
module tb_gcd_operand_loader;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        CMD_VALID, CMD_READY;
    logic [31:0] CMD_ADDR;
    logic [7:0]  CMD_LEN;
    logic        IN_VALID, IN_READY;
    logic [63:0] IN_DATA;
    logic [3:0]  M_AXI_AWID;
    logic [31:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWLOCK;
    logic [3:0]  M_AXI_AWCACHE;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [63:0] M_AXI_WDATA;
    logic [7:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic [3:0]  M_AXI_BID;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic        STS_VALID;
    logic [1:0]  STS_RESP;
    logic        BUSY;

    gcd_operand_loader dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .STS_VALID(STS_VALID), .STS_RESP(STS_RESP), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total    = 0;

    // Slave-side observation
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [63:0] w_q[$];
    logic        wl_q[$];
    int          in_cnt = 0, stab_err = 0, order_err = 0;
    logic        aw_pend = 1'b0, aw_done = 1'b0;
    logic [31:0] pa;
    logic [7:0]  pl;

    always @(posedge CLK) begin
        if (RESET) begin
            aw_done = 1'b0;
        end else begin
            if (aw_pend && (M_AXI_AWADDR !== pa || M_AXI_AWLEN !== pl || M_AXI_AWVALID !== 1'b1))
                stab_err++;
            if (M_AXI_WVALID && !aw_done) order_err++;
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_addr_q.push_back(M_AXI_AWADDR);
                aw_len_q.push_back(M_AXI_AWLEN);
                aw_done = 1'b1;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_q.push_back(M_AXI_WDATA);
                wl_q.push_back(M_AXI_WLAST);
                if (M_AXI_WLAST) aw_done = 1'b0;
            end
            if (IN_VALID && IN_READY) in_cnt++;
        end
        aw_pend = !RESET && M_AXI_AWVALID && !M_AXI_AWREADY;
        pa = M_AXI_AWADDR;
        pl = M_AXI_AWLEN;
    end

    // Per-run results
    logic [63:0] words[$];
    int          w_b, a_b, i_b, acc_wait, sts_cyc;
    logic        aw_first, got_sts, busy_at_sts, vld_after_rst;
    logic [1:0]  sts_resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference rules: 8-byte aligned and burst must end within its 4KB page.
    function automatic bit model_reject(input logic [31:0] a, input int len);
        return (a % 8 != 0) || ((a % 4096) + (len + 1) * 8 > 4096);
    endfunction

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back({$urandom(), $urandom()});
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run_cmd(input logic [31:0] addr, input logic [7:0] len, input int aw_delay,
                           input int stall, input logic [1:0] bresp, input int rst_after);
        int idx;
        logic hs;
        w_b = w_q.size(); a_b = aw_addr_q.size(); i_b = in_cnt;
        idx = 0; acc_wait = 0; sts_cyc = 0;
        got_sts = 1'b0; sts_resp = 2'b00; busy_at_sts = 1'b1; aw_first = 1'b0; vld_after_rst = 1'b1;
        M_AXI_BRESP = bresp;
        CMD_VALID = 1'b1; CMD_ADDR = addr; CMD_LEN = len;
        IN_VALID = 1'b1; IN_DATA = words[0]; M_AXI_WREADY = 1'b1;
        #1;
        while (!CMD_READY && acc_wait < 50) begin
            @(negedge CLK); acc_wait++; #1;
        end
        @(posedge CLK);
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge CLK);
            CMD_VALID = 1'b0;
            if (cyc == 1) aw_first = M_AXI_AWVALID;
            if (STS_VALID) begin
                got_sts = 1'b1; sts_resp = STS_RESP; busy_at_sts = BUSY; sts_cyc = cyc;
                break;
            end
            if (rst_after > 0 && w_q.size() - w_b >= rst_after) begin
                RESET = 1'b1;
                @(posedge CLK);
                @(negedge CLK);
                RESET = 1'b0;
                #1 vld_after_rst = M_AXI_AWVALID | M_AXI_WVALID | M_AXI_BREADY | BUSY | IN_READY;
                for (int k = 0; k < 4; k++) begin
                    @(negedge CLK);
                    if (STS_VALID) got_sts = 1'b1;
                end
                break;
            end
            M_AXI_AWREADY = (cyc > aw_delay);
            M_AXI_WREADY  = (stall == 0) || !(cyc >= 10 && cyc < 13);
            IN_VALID      = (idx <= int'(len)) && (stall == 0 || (cyc % 2) == 1);
            IN_DATA       = (idx <= int'(len)) ? words[idx] : 64'd0;
            M_AXI_BVALID  = (w_q.size() - w_b > int'(len));
            #1 hs = IN_VALID && IN_READY;
            @(posedge CLK);
            if (hs) idx++;
        end
        IN_VALID = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    endtask

    task automatic check_run(input string nm, input logic [31:0] addr, input int len,
                             input logic [1:0] bresp);
        int mism, nl, nw;
        bit rej;
        rej = model_reject(addr, len);
        nw  = w_q.size() - w_b;
        chk({nm, "_sts_seen"}, got_sts, 1);
        chk({nm, "_sts_resp"}, sts_resp, rej ? 2'b10 : bresp);
        chk({nm, "_busy_at_sts"}, busy_at_sts, 0);
        if (rej) begin
            chk({nm, "_aw_count"}, aw_addr_q.size() - a_b, 0);
            chk({nm, "_aw_first"}, aw_first, 0);
            chk({nm, "_in_taken"}, in_cnt - i_b, 0);
            chk({nm, "_sts_latency"}, sts_cyc, 1);
        end else begin
            mism = 0; nl = 0;
            for (int i = 0; i < nw; i++) begin
                if (i >= words.size() || w_q[w_b + i] !== words[i]) mism++;
                if (wl_q[w_b + i]) nl++;
            end
            chk({nm, "_aw_count"}, aw_addr_q.size() - a_b, 1);
            chk({nm, "_awaddr"}, aw_addr_q[a_b], addr);
            chk({nm, "_awlen"}, aw_len_q[a_b], len);
            chk({nm, "_beats"}, nw, len + 1);
            chk({nm, "_data_mism"}, mism, 0);
            chk({nm, "_wlast_final"}, wl_q[w_b + nw - 1], 1);
            chk({nm, "_wlast_count"}, nl, 1);
            chk({nm, "_in_taken"}, in_cnt - i_b, len + 1);
        end
    endtask

    initial begin
        logic [31:0] ra;
        int          rl;
        logic [1:0]  rb;

        RESET = 1'b1; CMD_VALID = 1'b0; CMD_ADDR = '0; CMD_LEN = '0;
        IN_VALID = 1'b0; IN_DATA = '0; M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BID = 4'hA; M_AXI_BRESP = 2'b00; M_AXI_BVALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid", M_AXI_WVALID, 0);
        chk("rst_bready", M_AXI_BREADY, 0);
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_cmd_ready", CMD_READY, 0);
        chk("rst_sts", {STS_VALID, STS_RESP, BUSY}, 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("const_aw", {M_AXI_AWID, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT},
            {4'd0, 3'd3, 2'b01, 1'b0, 4'd0, 3'd0});
        chk("const_wstrb", M_AXI_WSTRB, 8'hFF);

        // Basic 20-beat burst, words 1..20
        words.delete();
        for (int i = 0; i < 20; i++) words.push_back(64'(i + 1));
        run_cmd(32'h100, 8'd19, 0, 0, 2'b00, 0);
        check_run("t1", 32'h100, 19, 2'b00);
        @(negedge CLK);
        chk("t1_sts_one_cycle", STS_VALID, 0);

        // Stalled stream and WREADY gap
        fill_random(20);
        run_cmd(32'h100, 8'd19, 0, 1, 2'b00, 0);
        check_run("t2", 32'h100, 19, 2'b00);

        // Rejects: 4KB crossing and misalignment
        fill_random(2);
        run_cmd(32'hFF8, 8'd1, 0, 0, 2'b00, 0);
        check_run("t3_cross", 32'hFF8, 1, 2'b00);
        run_cmd(32'h104, 8'd0, 0, 0, 2'b00, 0);
        check_run("t3_align", 32'h104, 0, 2'b00);

        // SLVERR reported, then back-to-back command in the status cycle
        fill_random(4);
        run_cmd(32'h2000, 8'd3, 0, 0, 2'b10, 0);
        check_run("t4_slverr", 32'h2000, 3, 2'b10);
        fill_random(2);
        run_cmd(32'h2F00, 8'd1, 0, 0, 2'b00, 0);
        chk("t4_b2b_accept_wait", acc_wait, 0);
        chk("t4_b2b_aw_next", aw_first, 1);
        check_run("t4_b2b", 32'h2F00, 1, 2'b00);

        // Single beat with slow AWREADY; burst ending exactly on the page boundary
        fill_random(1);
        run_cmd(32'h3FF8, 8'd0, 5, 0, 2'b01, 0);
        check_run("t5", 32'h3FF8, 0, 2'b01);

        // Reset after beat 7, then recover
        fill_random(20);
        run_cmd(32'h400, 8'd19, 0, 0, 2'b00, 7);
        chk("t6_no_sts", got_sts, 0);
        chk("t6_valids_dropped", vld_after_rst, 0);
        chk("t6_beats", w_q.size() - w_b, 7);
        fill_random(4);
        run_cmd(32'h500, 8'd3, 0, 0, 2'b00, 0);
        check_run("t6_recover", 32'h500, 3, 2'b00);

        // Randomized commands against the reference rules
        for (int n = 0; n < 6; n++) begin
            ra = $urandom();
            if ($urandom_range(0, 3) != 0) ra[2:0] = 3'd0;
            if (n == 5) rl = 255; else rl = $urandom_range(0, 255);
            rb = 2'($urandom_range(0, 3));
            fill_random(rl + 1);
            run_cmd(ra, 8'(rl), $urandom_range(0, 3), $urandom_range(0, 1), rb, 0);
            check_run($sformatf("rnd%0d", n), ra, rl, rb);
        end

        chk("aw_stable_while_waiting", stab_err, 0);
        chk("no_w_before_aw", order_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
